// File: rtl/instruction_fetch_queue_pkg.sv
// Shared pipeline constants used by the fetch/decode stages.
//   NOP_INSTRUCTION : canonical RISC-V NOP (addi x0,x0,0)
//   clog2()         : ceiling log2, usable in constant expressions
package instruction_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_fifo_memory.sv
// Storage array for the instruction fetch queue.
//   clk     : write clock
//   wr_en   : write enable
//   wr_addr : write slot
//   wr_data : word written at rising edge when wr_en=1
//   rd_addr : read slot
//   rd_data : asynchronous read of the slot at rd_addr
// The array has no reset; occupancy tracking lives in the parent.
module fifo_memory #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   FLUSH               : drop all entries at the next edge (beats push/pop)
//   IF_VALID/IF_READY   : fetch-side handshake; IF_PC/IF_INSTRUCTION payload
//   ID_VALID/ID_READY   : decode-side handshake; ID_PC/ID_INSTRUCTION payload
//                         (PC=0 and a NOP are presented while empty)
//   COUNT               : number of occupied entries
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     IF_VALID,
  output logic                     IF_READY,
  input  logic [ADDRESS_WIDTH-1:0] IF_PC,
  input  logic [DATA_WIDTH-1:0]    IF_INSTRUCTION,
  output logic                     ID_VALID,
  input  logic                     ID_READY,
  output logic [ADDRESS_WIDTH-1:0] ID_PC,
  output logic [DATA_WIDTH-1:0]    ID_INSTRUCTION,
  output logic [clog2(DEPTH):0]    COUNT
);

  localparam int unsigned PTR_W   = clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic [CNT_W-1:0]   cnt;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] rd_entry;

  // Ready/valid come from registered occupancy only, so a full queue
  // refuses a push even in a cycle where it also pops.
  assign IF_READY = (cnt != CNT_W'(DEPTH));
  assign ID_VALID = (cnt != '0);

  assign push = IF_VALID & IF_READY & ~FLUSH;
  assign pop  = ID_VALID & ID_READY & ~FLUSH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (FLUSH) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  fifo_memory #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wp),
    .wr_data ({IF_PC, IF_INSTRUCTION}),
    .rd_addr (rp),
    .rd_data (rd_entry)
  );

  always_comb begin
    ID_PC          = '0;
    ID_INSTRUCTION = DATA_WIDTH'(NOP_INSTRUCTION);
    if (ID_VALID) begin
      ID_PC          = rd_entry[ENTRY_W-1 -: ADDRESS_WIDTH];
      ID_INSTRUCTION = rd_entry[DATA_WIDTH-1:0];
    end
  end

  assign COUNT = cnt;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTRUCTION;
  logic        ID_VALID;
  logic        ID_READY;
  logic [31:0] ID_PC;
  logic [31:0] ID_INSTRUCTION;
  logic [2:0]  COUNT;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t      sb[$];
  int unsigned prev_cnt;
  int unsigned checks;
  int unsigned errors;

  instruction_fetch_queue #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .DEPTH         (4)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .FLUSH          (FLUSH),
    .IF_VALID       (IF_VALID),
    .IF_READY       (IF_READY),
    .IF_PC          (IF_PC),
    .IF_INSTRUCTION (IF_INSTRUCTION),
    .ID_VALID       (ID_VALID),
    .ID_READY       (ID_READY),
    .ID_PC          (ID_PC),
    .ID_INSTRUCTION (ID_INSTRUCTION),
    .COUNT          (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge; compare against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && !FLUSH && ID_VALID && ID_READY) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL pop_unexpected: got pc %h with empty scoreboard at %0t", ID_PC, $time);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("pop_pc", ID_PC, e.pc);
        chk("pop_instr", ID_INSTRUCTION, e.ins);
      end
    end
  end

  task automatic check_state(input int unsigned exp_cnt);
    chk("count", 32'(COUNT), exp_cnt);
    chk("if_ready", 32'(IF_READY), 32'(exp_cnt != 4));
    chk("id_valid", 32'(ID_VALID), 32'(exp_cnt != 0));
    if (exp_cnt == 0) begin
      chk("empty_pc", ID_PC, 32'h0);
      chk("empty_nop", ID_INSTRUCTION, NOP);
    end else if (sb.size() > 0) begin
      chk("head_pc", ID_PC, sb[0].pc);
      chk("head_instr", ID_INSTRUCTION, sb[0].ins);
    end
  endtask

  // Drive one cycle of stimulus (called at posedge+1), record the expected
  // entry, then sample #1 after the consuming edge against exp_cnt.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input int unsigned exp_cnt);
    IF_VALID       = v;
    IF_PC          = pc;
    IF_INSTRUCTION = ins;
    ID_READY       = rdy;
    FLUSH          = fl;
    if (fl) sb.delete();
    else if (v && prev_cnt != 4) sb.push_back('{pc, ins});
    @(posedge CLK);
    #1;
    prev_cnt = exp_cnt;
    check_state(exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    prev_cnt       = 0;
    RST_N          = 1'b0;
    FLUSH          = 1'b0;
    IF_VALID       = 1'b0;
    IF_PC          = '0;
    IF_INSTRUCTION = '0;
    ID_READY       = 1'b0;

    // Reset values
    #2;
    check_state(0);
    #10 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Fill with decode stalled
    step(1'b1, 32'h0, 32'h00100093, 1'b0, 1'b0, 1);
    step(1'b1, 32'h4, 32'h00200093, 1'b0, 1'b0, 2);
    step(1'b1, 32'h8, 32'h00300093, 1'b0, 1'b0, 3);
    step(1'b1, 32'hC, 32'h00400093, 1'b0, 1'b0, 4);

    // Drain in order
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    // ID_READY while empty is ignored
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

    // Streaming, 10 pairs, two pointer wraps
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h200 + 32'(i) * 4, 32'h0A000093 + 32'(i) * 32'h100, 1'b1, 1'b0, 1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

    // Flush with concurrent push and pop
    step(1'b1, 32'h300, 32'h00500093, 1'b0, 1'b0, 1);
    step(1'b1, 32'h304, 32'h00600093, 1'b0, 1'b0, 2);
    step(1'b1, 32'h308, 32'h00700093, 1'b0, 1'b0, 3);
    step(1'b1, 32'h30C, 32'h00800093, 1'b1, 1'b1, 0);
    step(1'b1, 32'h100, 32'h00900093, 1'b0, 1'b0, 1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

    // Full with simultaneous pop: push refused, then held pair accepted
    step(1'b1, 32'h400, 32'h01000093, 1'b0, 1'b0, 1);
    step(1'b1, 32'h404, 32'h01100093, 1'b0, 1'b0, 2);
    step(1'b1, 32'h408, 32'h01200093, 1'b0, 1'b0, 3);
    step(1'b1, 32'h40C, 32'h01300093, 1'b0, 1'b0, 4);
    step(1'b1, 32'h410, 32'h01400093, 1'b1, 1'b0, 3);
    step(1'b1, 32'h410, 32'h01400093, 1'b0, 1'b0, 4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 2);

    // Asynchronous reset between edges with two entries queued
    IF_VALID = 1'b0;
    ID_READY = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ID_VALID), 32'h0);
    chk("async_rst_count", 32'(COUNT), 32'h0);
    sb.delete();
    prev_cnt = 0;
    #3 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Normal operation after reset
    step(1'b1, 32'h500, 32'h01500093, 1'b0, 1'b0, 1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

    chk("sb_leftover", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Decoupling buffer between the instruction fetch stage and the instruction decode stage of the RISC-V pipeline. It holds up to DEPTH fetched (PC, instruction) pairs in program order and accepts them with a valid/ready handshake on each side. Fetch can therefore run ahead while decode stalls. A single-cycle FLUSH discards all buffered entries on a branch, jump or trap redirect. When the queue is empty, decode sees a canonical NOP.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- DEPTH, 4, entry count; power of two, ≥2
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- FLUSH  input  1  discard all entries this cycle; overrides push and pop
- IF_VALID  input  1  fetch presents a valid pair
- IF_READY  output  1  queue can accept a pair
- IF_PC  input  ADDRESS_WIDTH  PC of the fetched instruction
- IF_INSTRUCTION  input  DATA_WIDTH  fetched instruction word
- ID_VALID  output  1  head entry valid for decode
- ID_READY  input  1  decode consumes the head entry
- ID_PC  output  ADDRESS_WIDTH  PC of the head entry
- ID_INSTRUCTION  output  DATA_WIDTH  instruction of the head entry
- COUNT  output  clog2(DEPTH)+1  number of occupied entries

## Operation
- State:
  - write pointer WP and read pointer RP, each clog2(DEPTH) bits, wrapping modulo DEPTH
  - occupancy register CNT, range 0..DEPTH
  - storage array of DEPTH × (ADDRESS_WIDTH+DATA_WIDTH)
- push = IF_VALID & IF_READY & ~FLUSH: write {IF_PC, IF_INSTRUCTION} at WP, then WP+1.
- pop = ID_VALID & ID_READY & ~FLUSH: RP+1.
- CNT next value:
  - push only: CNT+1
  - pop only: CNT−1
  - both or neither: unchanged
- IF_READY = (CNT != DEPTH).
  - Depends only on registered state, never on ID_READY.
  - Consequence: a full queue refuses a push even in a cycle where it pops.
- ID_VALID = (CNT != 0).
- ID_PC and ID_INSTRUCTION:
  - when ID_VALID=1: the entry at RP, read asynchronously
  - when ID_VALID=0: ID_PC = 0 and ID_INSTRUCTION = NOP (32'h00000013, addi x0,x0,0)
- COUNT = CNT.
- FLUSH=1: at the next edge WP, RP and CNT all go to 0. Any concurrent push or pop is ignored, and the storage contents are don't-care.
- Order is strictly FIFO; entries are never reordered or dropped except by FLUSH.
- Protocol rules:
  - Fetch holds IF_PC/IF_INSTRUCTION stable while IF_VALID=1 and IF_READY=0.
  - The queue holds ID_* stable while ID_VALID=1 and ID_READY=0.

## Timing
- Reset (RST_N low, asynchronous): WP=RP=CNT=0. Outputs are IF_READY=1, ID_VALID=0, ID_PC=0, ID_INSTRUCTION=NOP, COUNT=0. Storage is not reset.
- Reset deassertion is synchronised externally. The first push may occur on the first rising edge with RST_N=1.
- Latency: a pair pushed at edge N is visible on ID_* with ID_VALID=1 after edge N. There is no same-cycle bypass, so an empty queue adds one cycle.
- Throughput: one push and one pop per cycle sustained when 0 < CNT < DEPTH.
- Full (CNT=DEPTH): IF_READY=0. A pop at edge N makes IF_READY=1 after edge N.
- Empty (CNT=0): ID_VALID=0, and ID_READY is ignored.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap or bubble.
- FLUSH asserted at edge N: after edge N, ID_VALID=0 and IF_READY=1. A push at edge N+1 is accepted normally.
- RST_N assertion mid-operation discards all entries immediately, without waiting for a clock edge.

## Structure
- Shared constants file used across pipeline stages holds:
  - NOP_INSTRUCTION = 32'h00000013
  - the clog2 function
- One natural sub-module, fifo_memory:
  - DEPTH × (ADDRESS_WIDTH+DATA_WIDTH) register array
  - single synchronous write port (enable, address, data) and single asynchronous read port
  - no reset
- Pointer, count and handshake logic lives in instruction_fetch_queue.

## Test plan
- Reset then fill: push PCs 0x0, 0x4, 0x8, 0xC with instructions 0x00100093..0x00400093 and ID_READY=0. Required: COUNT 1,2,3,4; IF_READY=0 after the 4th push; ID_PC=0x0 throughout.
- Drain in order, using the state left by the fill test: hold ID_READY=1 for 4 cycles. Required: ID_PC 0x0, 0x4, 0x8, 0xC on successive cycles; then ID_VALID=0 and ID_INSTRUCTION=0x00000013.
- Streaming with wrap: continuous push and pop of 10 pairs with PC incrementing by 4. Required: COUNT stays at 1 after the first edge; pairs arrive in order across two pointer wraps; zero bubbles.
- Flush: 3 entries queued, then FLUSH=1 together with IF_VALID=1 and ID_READY=1. Required: after the edge COUNT=0, ID_VALID=0, the pushed pair is dropped and no pop is counted. The next push of PC 0x100 appears one cycle later.
- Full with simultaneous pop: CNT=4, IF_VALID=1, ID_READY=1. Required: no push that cycle and COUNT=3 after the edge; the held pair is accepted on the next edge.
- Async reset mid-stream: drop RST_N between edges with CNT=2. Required: ID_VALID=0 and COUNT=0 immediately, without a clock edge.
